// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if
//   Handshake bundle between an operand producer / result consumer and the
//   shift_add_multiplier.
//   Parameter: data_width - operand width; product is 2*data_width bits.
//   Signals:
//     in_valid  - producer has operands a/b on the bus
//     in_ready  - multiplier is idle and can take operands
//     a, b      - multiplicand / multiplier, unsigned
//     out_valid - product is valid
//     out_ready - consumer takes product
//     product   - a*b, unsigned, full width
//   Modports: slave = multiplier side, master = producer/consumer side.
interface shift_add_multiplier_if #(
   parameter int data_width = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic [data_width-1:0]     a;
   logic [data_width-1:0]     b;
   logic                      out_valid;
   logic                      out_ready;
   logic [2*data_width-1:0]   product;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// full_adder
//   Ripple-carry adder: {cout, sum} = x + y + cin.
//   Ports: x, y (data_width), cin (1) in; sum (data_width), cout (1) out.
//
// shift_add_multiplier
//   Sequential unsigned multiplier. Accepts a/b over a valid/ready handshake,
//   runs data_width add-and-shift iterations through one full_adder, then
//   presents the 2*data_width-bit product over a valid/ready handshake.
//   Ports: clk, rst_n (async, active-low) plain; bus (slave modport of
//   shift_add_multiplier_if) carries both handshakes and data.
module full_adder #(
   parameter int data_width = 8
) (
   input  logic [data_width-1:0] x,
   input  logic [data_width-1:0] y,
   input  logic                  cin,
   output logic [data_width-1:0] sum,
   output logic                  cout
);
   logic [data_width:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < data_width; gi++) begin : g_bit
         assign sum[gi]       = x[gi] ^ y[gi] ^ carry[gi];
         assign carry[gi + 1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
      end
   endgenerate

   assign cout = carry[data_width];
endmodule

module shift_add_multiplier #(
   parameter int data_width = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   shift_add_multiplier_if.slave       bus
);
   localparam int cnt_w = $clog2(data_width + 1);
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(data_width - 1);

   // Encoding chosen so in_ready and out_valid are single state bits:
   // bit0 set only in IDLE, bit1 set only in HOLD.
   localparam logic [1:0] st_idle = 2'b01;
   localparam logic [1:0] st_run  = 2'b00;
   localparam logic [1:0] st_hold = 2'b10;

   logic [1:0]            state_reg,  state_next;
   logic [data_width-1:0] mcand_reg,  mcand_next;
   logic [data_width-1:0] acc_hi_reg, acc_hi_next;
   logic [data_width-1:0] acc_lo_reg, acc_lo_next;
   logic [cnt_w-1:0]      cnt_reg,    cnt_next;

   logic [data_width-1:0] addend;
   logic [data_width-1:0] sum;
   logic                  cout;

   // Current multiplier LSB selects whether the multiplicand is added.
   assign addend = acc_lo_reg[0] ? mcand_reg : '0;

   full_adder #(
      .data_width (data_width)
   ) u_adder (
      .x    (acc_hi_reg),
      .y    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      state_next  = state_reg;
      mcand_next  = mcand_reg;
      acc_hi_next = acc_hi_reg;
      acc_lo_next = acc_lo_reg;
      cnt_next    = cnt_reg;
      case (state_reg)
         st_idle: begin
            if (bus.in_valid) begin
               mcand_next  = bus.a;
               acc_hi_next = '0;
               acc_lo_next = bus.b;
               cnt_next    = '0;
               state_next  = st_run;
            end
         end
         st_run: begin
            // Carry-out lands in the MSB of the shifted upper half, so no
            // product bit is ever lost; the consumed multiplier bit drops
            // off the bottom as a product bit shifts in from the top.
            {acc_hi_next, acc_lo_next} = {cout, sum, acc_lo_reg[data_width-1:1]};
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == last_cnt) begin
               state_next = st_hold;
            end
         end
         st_hold: begin
            if (bus.out_ready) begin
               state_next = st_idle;
            end
         end
         default: begin
            state_next = st_idle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= st_idle;
         mcand_reg  <= '0;
         acc_hi_reg <= '0;
         acc_lo_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         mcand_reg  <= mcand_next;
         acc_hi_reg <= acc_hi_next;
         acc_lo_reg <= acc_lo_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign bus.in_ready  = state_reg[0];
   assign bus.out_valid = state_reg[1];
   assign bus.product   = {acc_hi_reg, acc_lo_reg};
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier: an 8-bit instance for the main
//   function, handshake and reset behaviour, and a 2-bit instance swept over
//   all operand pairs. Inputs are driven and outputs sampled 1 time unit after
//   each rising edge.
module tb_shift_add_multiplier;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   shift_add_multiplier_if #(.data_width(8)) m8 ();
   shift_add_multiplier_if #(.data_width(2)) m2 ();

   shift_add_multiplier #(.data_width(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m8)
   );

   shift_add_multiplier #(.data_width(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m2)
   );

   logic [3:0] exp2_tab [0:15] = '{4'd0, 4'd0, 4'd0, 4'd0,
                                   4'd0, 4'd1, 4'd2, 4'd3,
                                   4'd0, 4'd2, 4'd4, 4'd6,
                                   4'd0, 4'd3, 4'd6, 4'd9};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_ready8(input string tag);
      for (int i = 0; i < 40 && m8.in_ready !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      check({tag, "_ready"}, 32'(m8.in_ready), 32'd1);
   endtask

   // One 8-bit multiply. hold=0 keeps out_ready high; hold>0 holds it low for
   // that many HOLD cycles before releasing.
   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] expv, input int hold, input string tag);
      int lat;
      bit got;
      m8.out_ready = (hold == 0);
      wait_ready8(tag);
      m8.a = a;
      m8.b = b;
      m8.in_valid = 1'b1;
      @(posedge clk); #1;
      m8.in_valid = 1'b0;
      m8.a = 8'h55;
      m8.b = 8'hAA;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (m8.out_valid === 1'b1) got = 1'b1;
      end
      check({tag, "_lat"}, 32'(lat), 32'd8);
      check({tag, "_prod"}, 32'(m8.product), 32'(expv));
      $display("txn w8 %s a=%0d b=%0d product=%0h latency=%0d", tag, a, b, m8.product, lat);
      if (hold > 0) begin
         check({tag, "_busy"}, 32'(m8.in_ready), 32'd0);
         for (int k = 1; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(m8.out_valid), 32'd1);
            check({tag, "_hold_prod"}, 32'(m8.product), 32'(expv));
            check({tag, "_hold_busy"}, 32'(m8.in_ready), 32'd0);
         end
         m8.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(m8.out_valid), 32'd0);
      check({tag, "_idle"}, 32'(m8.in_ready), 32'd1);
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic [3:0] expv);
      int lat;
      bit got;
      m2.out_ready = 1'b1;
      check("w2_ready", 32'(m2.in_ready), 32'd1);
      m2.a = a;
      m2.b = b;
      m2.in_valid = 1'b1;
      @(posedge clk); #1;
      m2.in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (m2.out_valid === 1'b1) got = 1'b1;
      end
      check("w2_lat", 32'(lat), 32'd2);
      check("w2_prod", 32'(m2.product), 32'(expv));
      $display("txn w2 a=%0d b=%0d product=%0h latency=%0d", a, b, m2.product, lat);
      @(posedge clk); #1;
   endtask

   initial begin
      int acc0;
      int acc1;
      int lat;
      bit seen;
      bit got;
      logic [7:0] junk;
      logic [3:0] idx;

      m8.in_valid = 1'b0; m8.a = '0; m8.b = '0; m8.out_ready = 1'b1;
      m2.in_valid = 1'b0; m2.a = '0; m2.b = '0; m2.out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_in_ready", 32'(m8.in_ready), 32'd1);
      check("rst_out_valid", 32'(m8.out_valid), 32'd0);
      check("rst_product", 32'(m8.product), 32'd0);
      check("rst2_in_ready", 32'(m2.in_ready), 32'd1);
      check("rst2_out_valid", 32'(m2.out_valid), 32'd0);
      check("rst2_product", 32'(m2.product), 32'd0);
      #5 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic, carry path, zero, backpressure
      run8(8'd13,  8'd11,  16'h008F, 0, "basic");
      run8(8'd255, 8'd255, 16'hFE01, 0, "ff_ff");
      run8(8'd255, 8'd1,   16'h00FF, 0, "ff_01");
      run8(8'd1,   8'd255, 16'h00FF, 0, "01_ff");
      run8(8'd0,   8'd200, 16'h0000, 0, "zero");
      run8(8'd7,   8'd9,   16'h003F, 5, "bpress");

      // Busy-ignore: in_valid stays high with changing operands during RUN
      m8.out_ready = 1'b1;
      wait_ready8("busy");
      m8.a = 8'd3;
      m8.b = 8'd5;
      m8.in_valid = 1'b1;
      @(posedge clk); #1;
      acc0 = cyc;
      acc1 = acc0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (m8.in_ready === 1'b1) begin
            m8.a = 8'd9;
            m8.b = 8'd4;
            @(posedge clk); #1;
            acc1 = cyc;
            break;
         end
         if (m8.out_valid === 1'b1) begin
            seen = 1'b1;
            check("busy_first_prod", 32'(m8.product), 32'd15);
         end
         junk = 8'hC3 ^ 8'(i);
         m8.a = junk;
         m8.b = ~junk;
         @(posedge clk); #1;
      end
      check("busy_first_seen", 32'(seen), 32'd1);
      check("busy_interval", 32'(acc1 - acc0), 32'd10);
      m8.in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (m8.out_valid === 1'b1) got = 1'b1;
      end
      check("busy_second_lat", 32'(lat), 32'd8);
      check("busy_second_prod", 32'(m8.product), 32'd36);
      $display("txn w8 busy a=9 b=4 product=%0h latency=%0d", m8.product, lat);
      @(posedge clk); #1;

      // Reset mid-run, asynchronous
      wait_ready8("midrst");
      m8.a = 8'd100;
      m8.b = 8'd3;
      m8.in_valid = 1'b1;
      @(posedge clk); #1;
      m8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(m8.in_ready), 32'd1);
      check("midrst_out_valid", 32'(m8.out_valid), 32'd0);
      check("midrst_product", 32'(m8.product), 32'd0);
      $display("txn w8 midrst in_ready=%0d out_valid=%0d product=%0h",
               m8.in_ready, m8.out_valid, m8.product);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run8(8'd6, 8'd7, 16'd42, 0, "after_rst");

      // Width-2 sweep
      for (int i = 0; i < 16; i++) begin
         idx = 4'(i);
         run2(idx[3:2], idx[1:0], exp2_tab[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
